// File: rtl/logic_pkg.sv
// Shared definitions for the logical-unit checking blocks.
//   cap_state_t : capture FSM states (COLLECT, DONE, CONFLICT)
//   ROWS        : number of truth-table rows of a 2-input function
//   row_idx     : maps an (a, b) input pair to its truth-table row {a,b}
package logic_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DONE     = 2'd1,
    CONFLICT = 2'd2
  } cap_state_t;

  localparam int ROWS = 4;

  function automatic logic [1:0] row_idx(input logic a, input logic b);
    return {a, b};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (highest priority)
//   clr   : synchronous clear to zero (beats inc)
//   inc   : count one event this cycle
//   cnt   : current count, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state is written with <= only, so every flop samples
  // the pre-edge values of its neighbours regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/func_capture.sv
// Truth-table capture: rebuilds the 4-bit function code of a 2-input logical
// unit from observed (a, b, out_obs) samples, flags completion once all four
// rows are seen, and raises a sticky conflict on any inconsistent sample.
//   clk, rst_n    : clock, synchronous active-low reset
//   clear         : synchronous soft clear of all capture state
//   sample_valid  : a / b / out_obs carry a sample
//   sample_ready  : sample accepted this cycle (low only in CONFLICT)
//   a, b, out_obs : observed inputs and output
//   func          : reconstructed function code, bit index = {a,b}
//   seen          : rows observed so far, same indexing as func
//   done          : all rows seen with no conflict
//   done_pulse    : one cycle high on entry to DONE
//   conflict      : sticky mismatch flag
//   sample_cnt    : accepted samples, saturating
module func_capture
  import logic_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             a,
  input  logic             b,
  input  logic             out_obs,
  output logic [3:0]       func,
  output logic [3:0]       seen,
  output logic             done,
  output logic             done_pulse,
  output logic             conflict,
  output logic [CNT_W-1:0] sample_cnt
);

  cap_state_t      state_q, state_d;
  logic [ROWS-1:0] func_q, func_d;
  logic [ROWS-1:0] seen_q, seen_d;
  logic            pulse_d;
  logic            done_q, conflict_q, pulse_q;
  logic            accept;
  logic [1:0]      r;

  // Ready depends on state only, so upstream never sees a combinational
  // path from sample_valid back to sample_ready.
  assign sample_ready = (state_q != CONFLICT);
  assign accept       = sample_valid & sample_ready;
  assign r            = row_idx(a, b);

  // NOTE: every signal written here gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    seen_d  = seen_q;
    pulse_d = 1'b0;
    if (accept) begin
      case (state_q)
        COLLECT: begin
          if (seen_q[r] && (func_q[r] != out_obs)) begin
            // Leave func/seen untouched so the conflicting row stays visible.
            state_d = CONFLICT;
          end else begin
            func_d[r] = out_obs;
            seen_d[r] = 1'b1;
            if (&seen_d) begin
              state_d = DONE;
              pulse_d = 1'b1;
            end
          end
        end
        DONE: begin
          if (func_q[r] != out_obs) state_d = CONFLICT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q    <= COLLECT;
      func_q     <= '0;
      seen_q     <= '0;
      pulse_q    <= 1'b0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      seen_q     <= seen_d;
      pulse_q    <= pulse_d;
      done_q     <= (state_d == DONE);
      conflict_q <= (state_d == CONFLICT);
    end
  end

  // The counter applies its own rst_n > clr > inc priority, so a sample
  // arriving in a clear cycle is dropped without extra gating here.
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (accept),
    .cnt   (sample_cnt)
  );

  assign func       = func_q;
  assign seen       = seen_q;
  assign done       = done_q;
  assign done_pulse = pulse_q;
  assign conflict   = conflict_q;

endmodule
